// File: rtl/pkg_dtypes.sv
// rtl/pkg_dtypes.sv - shared exec-unit datatypes: queue opcodes, ALU issue states, perf width
package pkg_dtypes;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0,
      OP_ADD = 4'd1,
      OP_SUB = 4'd2,
      OP_AND = 4'd3,
      OP_OR  = 4'd4,
      OP_XOR = 4'd5,
      OP_SHL = 4'd6,
      OP_SHR = 4'd7
   } type_iqueue_opcode;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } type_alu_issue_state;

   localparam int ALU_ISSUE_PERF_CNT_W = 32;

endpackage

// File: rtl/alu_issue_sched_rr_arbiter.sv
// rtl/alu_issue_sched_rr_arbiter.sv - combinational round-robin arbiter, search starts after last grant
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   logic [IW-1:0] w_cand;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      w_cand  = last_i;
      for (int i = 0; i < N; i++) begin
         w_cand = (w_cand == IW'(N - 1)) ? '0 : w_cand + 1'b1;
         if (!any_o && req_i[w_cand]) begin
            any_o           = 1'b1;
            grant_o[w_cand] = 1'b1;
            idx_o           = w_cand;
         end
      end
   end

endmodule

// File: rtl/alu_issue_sched.sv
// rtl/alu_issue_sched.sv - round-robin single-slot issue scheduler with watchdog in front of one ALU
// Optional perf counters: ALU_ISSUE_PERF_CNT_EN
module alu_issue_sched
   import pkg_dtypes::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [NUM_REQ-1:0]              req_valid_i,
   input  type_iqueue_opcode               req_instr_i [NUM_REQ],
   output logic [NUM_REQ-1:0]              req_grant_o,
   input  logic                            flush_i,
   output type_iqueue_opcode               curr_instr_o,
   output logic                            curr_instr_valid_o,
   input  logic                            alu_ready_i,
   output logic                            stall_o,
   output logic [ALU_ISSUE_PERF_CNT_W-1:0] perf_issued_o,
   output logic [ALU_ISSUE_PERF_CNT_W-1:0] perf_stall_cyc_o
);

   localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT_CYCLES);

   type_alu_issue_state r_state;
   logic [IW-1:0]       r_rr_ptr;
   type_iqueue_opcode   r_instr;
   logic                r_valid;
   logic [WDW-1:0]      r_wdog;

   logic [NUM_REQ-1:0]  w_grant;
   logic [IW-1:0]       w_win_idx;
   logic                w_any;
   logic                w_slot_free;
   logic                w_accept;

   rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
      .req_i   (req_valid_i),
      .last_i  (r_rr_ptr),
      .grant_o (w_grant),
      .idx_o   (w_win_idx),
      .any_o   (w_any)
   );

   // reset_n gates the grant so nothing is handed out while the block is held in reset
   assign w_slot_free = (r_state == IDLE) || alu_ready_i;
   assign w_accept    = reset_n && !flush_i && w_any && w_slot_free;
   assign req_grant_o = w_accept ? w_grant : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_rr_ptr <= IW'(NUM_REQ - 1);
         r_instr  <= OP_NOP;
         r_valid  <= 1'b0;
         r_wdog   <= '0;
      end else if (flush_i) begin
         r_state <= IDLE;
         r_valid <= 1'b0;
         r_wdog  <= '0;
      end else if (w_accept) begin
         r_state  <= BUSY;
         r_instr  <= req_instr_i[w_win_idx];
         r_valid  <= 1'b1;
         r_rr_ptr <= w_win_idx;
         r_wdog   <= '0;
      end else if (r_state == BUSY) begin
         if (alu_ready_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_wdog  <= '0;
         end else if (r_wdog != WD_MAX) begin
            r_wdog <= r_wdog + 1'b1;
         end
      end
   end

   assign curr_instr_o       = r_instr;
   assign curr_instr_valid_o = r_valid;
   assign stall_o            = (r_state == BUSY) && (r_wdog == WD_MAX);

`ifdef ALU_ISSUE_PERF_CNT_EN
   logic [ALU_ISSUE_PERF_CNT_W-1:0] r_perf_issued;
   logic [ALU_ISSUE_PERF_CNT_W-1:0] r_perf_stall;

   // counters survive flush; only reset clears them
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_perf_issued <= '0;
         r_perf_stall  <= '0;
      end else begin
         if (w_accept)
            r_perf_issued <= r_perf_issued + 1'b1;
         if ((r_state == BUSY) && !alu_ready_i)
            r_perf_stall <= r_perf_stall + 1'b1;
      end
   end

   assign perf_issued_o    = r_perf_issued;
   assign perf_stall_cyc_o = r_perf_stall;
`else
   assign perf_issued_o    = '0;
   assign perf_stall_cyc_o = '0;
`endif

endmodule

// File: tb/tb_alu_issue_sched.sv
// tb/tb_alu_issue_sched.sv - directed table-driven bench for alu_issue_sched (NUM_REQ=4, TIMEOUT_CYCLES=8)
module tb_alu_issue_sched;
   import pkg_dtypes::*;

   localparam int NR = 4;
   localparam int TO = 8;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NR-1:0]     req_valid_i;
   type_iqueue_opcode req_instr_i [NR];
   logic [NR-1:0]     req_grant_o;
   logic              flush_i;
   type_iqueue_opcode curr_instr_o;
   logic              curr_instr_valid_o;
   logic              alu_ready_i;
   logic              stall_o;
   logic [31:0]       perf_issued_o;
   logic [31:0]       perf_stall_cyc_o;

   alu_issue_sched #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .req_valid_i        (req_valid_i),
      .req_instr_i        (req_instr_i),
      .req_grant_o        (req_grant_o),
      .flush_i            (flush_i),
      .curr_instr_o       (curr_instr_o),
      .curr_instr_valid_o (curr_instr_valid_o),
      .alu_ready_i        (alu_ready_i),
      .stall_o            (stall_o),
      .perf_issued_o      (perf_issued_o),
      .perf_stall_cyc_o   (perf_stall_cyc_o)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   typedef struct packed {
      logic [3:0]        v;
      logic              r;
      logic              f;
      logic [3:0]        g;
      logic              val;
      type_iqueue_opcode ins;
   } vec_t;

   vec_t tbl [16];

   task automatic cyc(input logic [3:0] v, input logic r);
      req_valid_i = v;
      alu_ready_i = r;
      flush_i     = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   int exp_iss;
   int exp_stl;

   initial begin
      // slot k carries opcode k+1 during the table phase
      tbl[0]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, OP_ADD};
      tbl[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, OP_SUB};
      tbl[2]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, OP_AND};
      tbl[3]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, OP_OR};
      tbl[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, OP_ADD};
      tbl[5]  = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, OP_SUB};
      tbl[6]  = '{4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1, OP_OR};
      tbl[7]  = '{4'b1010, 1'b1, 1'b0, 4'b0010, 1'b1, OP_SUB};
      tbl[8]  = '{4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1, OP_OR};
      tbl[9]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, OP_NOP};
      tbl[10] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, OP_NOP};
      tbl[11] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, OP_ADD};
      tbl[12] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, OP_ADD};
      tbl[13] = '{4'b0001, 1'b1, 1'b1, 4'b0000, 1'b0, OP_NOP};
      tbl[14] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, OP_ADD};
      tbl[15] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, OP_NOP};

      req_instr_i[0] = OP_ADD;
      req_instr_i[1] = OP_SUB;
      req_instr_i[2] = OP_AND;
      req_instr_i[3] = OP_OR;
      reset_n     = 1'b0;
      req_valid_i = 4'b1111;
      alu_ready_i = 1'b0;
      flush_i     = 1'b0;

      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset grant", req_grant_o, 4'b0000);
      chk("reset valid", curr_instr_valid_o, 1'b0);
      chk("reset instr", curr_instr_o, OP_NOP);
      chk("reset stall", stall_o, 1'b0);
      chk("reset perf_issued", perf_issued_o, 0);
      chk("reset perf_stall", perf_stall_cyc_o, 0);

      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         req_valid_i = tbl[i].v;
         alu_ready_i = tbl[i].r;
         flush_i     = tbl[i].f;
         #1;
         chk($sformatf("row%0d grant", i), req_grant_o, tbl[i].g);
         @(posedge clk);
         #1;
         chk($sformatf("row%0d valid", i), curr_instr_valid_o, tbl[i].val);
         if (tbl[i].val)
            chk($sformatf("row%0d instr", i), curr_instr_o, tbl[i].ins);
         chk($sformatf("row%0d stall", i), stall_o, 1'b0);
         @(negedge clk);
      end
      flush_i = 1'b0;

`ifdef ALU_ISSUE_PERF_CNT_EN
      exp_iss = 11;
      exp_stl = 1;
`else
      exp_iss = 0;
      exp_stl = 0;
`endif
      chk("table perf_issued", perf_issued_o, exp_iss);
      chk("table perf_stall", perf_stall_cyc_o, exp_stl);

      // hold: ADD from slot 2, ALU not ready for 5 cycles
      req_instr_i[2] = OP_ADD;
      req_valid_i = 4'b0100;
      alu_ready_i = 1'b0;
      #1;
      chk("hold issue grant", req_grant_o, 4'b0100);
      @(posedge clk);
      #1;
      chk("hold issue instr", curr_instr_o, OP_ADD);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         req_valid_i = 4'b1111;
         alu_ready_i = 1'b0;
         #1;
         chk($sformatf("hold%0d grant", i), req_grant_o, 4'b0000);
         @(posedge clk);
         #1;
         chk($sformatf("hold%0d instr", i), curr_instr_o, OP_ADD);
         chk($sformatf("hold%0d valid", i), curr_instr_valid_o, 1'b1);
         @(negedge clk);
      end
      alu_ready_i = 1'b1;
      #1;
      chk("hold release grant", req_grant_o, 4'b1000);
      @(posedge clk);
      #1;
      chk("hold release instr", curr_instr_o, OP_OR);
      @(negedge clk);

      // watchdog: BUSY cycle n carries a count of n-1
      for (int n = 1; n <= 10; n++) begin
         req_valid_i = 4'b0000;
         alu_ready_i = 1'b0;
         #1;
         chk($sformatf("wdog cycle%0d stall", n), stall_o, (n >= 9) ? 1'b1 : 1'b0);
         @(posedge clk);
         @(negedge clk);
      end
      alu_ready_i = 1'b1;
      #1;
      chk("wdog saturated stall", stall_o, 1'b1);
      @(posedge clk);
      #1;
      chk("wdog retire stall", stall_o, 1'b0);
      chk("wdog retire valid", curr_instr_valid_o, 1'b0);
      @(negedge clk);

      // reset while BUSY drops the held instruction
      req_valid_i = 4'b0001;
      alu_ready_i = 1'b1;
      @(posedge clk);
      #1;
      chk("midreset pre valid", curr_instr_valid_o, 1'b1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("midreset valid", curr_instr_valid_o, 1'b0);
      chk("midreset grant", req_grant_o, 4'b0000);
      @(negedge clk);
      reset_n = 1'b1;

      // perf: 3 issues, 4 stall cycles
      cyc(4'b0001, 1'b0);
      cyc(4'b0000, 1'b0);
      cyc(4'b0000, 1'b0);
      cyc(4'b0001, 1'b1);
      cyc(4'b0000, 1'b0);
      cyc(4'b0000, 1'b0);
      cyc(4'b0001, 1'b1);
      cyc(4'b0000, 1'b1);
      #1;
`ifdef ALU_ISSUE_PERF_CNT_EN
      exp_iss = 3;
      exp_stl = 4;
`else
      exp_iss = 0;
      exp_stl = 0;
`endif
      chk("perf_issued", perf_issued_o, exp_iss);
      chk("perf_stall_cyc", perf_stall_cyc_o, exp_stl);
      chk("perf end valid", curr_instr_valid_o, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
